// File: rtl/dma_ci_sequencer.sv
// Custom-instruction front end that programs the bus DMA engine and sequences one transfer.
// CI completion one cycle after start; config outputs track their registers with no added delay.
// No backpressure: every matching CI completes; parameter writes and launches are dropped while busy.
module dma_ci_sequencer #(
    parameter logic [7:0] customId       = 8'h00,
    parameter int         LAUNCH_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] bAddrOut,
    output logic [8:0]  mAddrOut,
    output logic [9:0]  blockSOut,
    output logic [7:0]  burstSOut,
    output logic [1:0]  controlOut,
    input  logic [3:0]  engineStatusIn
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_FIN} state_t;

    localparam logic [15:0] TO_LAST = 16'(LAUNCH_TIMEOUT - 1);

    state_t      state;
    logic [1:0]  last_dir;
    logic        busy;
    logic        done_flag;
    logic        err_flag;
    logic        to_flag;
    logic [15:0] cyc_cnt;
    logic [15:0] to_cnt;

    logic        ci_hit;
    logic        ci_wr;
    logic [2:0]  sel;
    logic        code_ok;
    logic [31:0] rd_dat;
    logic        unused_bits;

    assign ci_hit  = start && (ciN == customId);
    assign ci_wr   = valueA[9];
    assign sel     = valueA[12:10];
    assign code_ok = (valueB[1:0] == 2'b01) || (valueB[1:0] == 2'b10);
    assign unused_bits = ^{valueA[31:13], valueA[8:0]};

    always_comb begin
        rd_dat = '0;
        case (sel)
            3'd1: rd_dat = bAddrOut;
            3'd2: rd_dat = {23'd0, mAddrOut};
            3'd3: rd_dat = {22'd0, blockSOut};
            3'd4: rd_dat = {24'd0, burstSOut};
            3'd5: rd_dat = {20'd0, engineStatusIn, 2'd0, to_flag, err_flag, done_flag, busy, last_dir};
            3'd6: rd_dat = {16'd0, cyc_cnt};
            default: rd_dat = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            done       <= 1'b0;
            result     <= '0;
            bAddrOut   <= '0;
            mAddrOut   <= '0;
            blockSOut  <= '0;
            burstSOut  <= '0;
            controlOut <= 2'b00;
            last_dir   <= 2'b00;
            busy       <= 1'b0;
            done_flag  <= 1'b0;
            err_flag   <= 1'b0;
            to_flag    <= 1'b0;
            cyc_cnt    <= '0;
            to_cnt     <= '0;
        end else begin
            done   <= ci_hit;
            result <= (ci_hit && !ci_wr) ? rd_dat : '0;

            if (ci_hit && ci_wr && !busy) begin
                case (sel)
                    3'd1: bAddrOut  <= valueB;
                    3'd2: mAddrOut  <= valueB[8:0];
                    3'd3: blockSOut <= valueB[9:0];
                    3'd4: burstSOut <= valueB[7:0];
                    default: ;
                endcase
            end

            // Sticky clear lands first so that flags raised by the FSM this same edge survive.
            if (ci_hit && ci_wr && (sel == 3'd5) && valueB[31]) begin
                done_flag <= 1'b0;
                err_flag  <= 1'b0;
                to_flag   <= 1'b0;
            end

            case (state)
                S_ARM: begin
                    if (engineStatusIn != 4'd0) begin
                        state   <= S_RUN;
                        cyc_cnt <= 16'd1;
                        if (engineStatusIn == 4'd7) err_flag <= 1'b1;
                    end else if (to_cnt == TO_LAST) begin
                        state      <= S_IDLE;
                        to_flag    <= 1'b1;
                        err_flag   <= 1'b1;
                        busy       <= 1'b0;
                        controlOut <= 2'b00;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                S_RUN: begin
                    if (engineStatusIn == 4'd0) begin
                        state      <= S_FIN;
                        controlOut <= 2'b00;
                        done_flag  <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        if (cyc_cnt != 16'hFFFF) cyc_cnt <= cyc_cnt + 16'd1;
                        if (engineStatusIn == 4'd7) err_flag <= 1'b1;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: ;
            endcase

            // Launch is evaluated last so a launch in the finishing cycle re-arms immediately.
            if (ci_hit && ci_wr && (sel == 3'd5) && code_ok && !busy) begin
                if (blockSOut == 10'd0) begin
                    err_flag <= 1'b1;
                end else begin
                    state      <= S_ARM;
                    controlOut <= valueB[1:0];
                    last_dir   <= valueB[1:0];
                    busy       <= 1'b1;
                    to_cnt     <= '0;
                    cyc_cnt    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_ci_sequencer.sv
// Directed bench for dma_ci_sequencer: per-cycle comparison against a transfer-level model
// plus literal expectations for each scenario.
module tb_dma_ci_sequencer;

    localparam logic [7:0] ID = 8'h00;
    localparam int         LT = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  ciN = 8'h00;
    logic [31:0] valueA = '0;
    logic [31:0] valueB = '0;
    logic [3:0]  eng = 4'd0;
    logic        done;
    logic [31:0] result;
    logic [31:0] bAddrOut;
    logic [8:0]  mAddrOut;
    logic [9:0]  blockSOut;
    logic [7:0]  burstSOut;
    logic [1:0]  controlOut;

    int total = 0;
    int bad = 0;

    dma_ci_sequencer #(.customId(ID), .LAUNCH_TIMEOUT(LT)) dut (
        .clock(clock), .reset(reset), .start(start), .ciN(ciN),
        .valueA(valueA), .valueB(valueB), .done(done), .result(result),
        .bAddrOut(bAddrOut), .mAddrOut(mAddrOut), .blockSOut(blockSOut),
        .burstSOut(burstSOut), .controlOut(controlOut), .engineStatusIn(eng)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: register file plus a transfer phase (0 none, 1 waiting for engine, 2 engine active, 3 wrap-up).
    logic [31:0] m_b = '0;
    logic [8:0]  m_m = '0;
    logic [9:0]  m_bs = '0;
    logic [7:0]  m_br = '0;
    logic [1:0]  m_dir = '0, m_ctrl = '0;
    logic        m_busy = 0, m_dn = 0, m_err = 0, m_to = 0, m_done = 0;
    logic [15:0] m_cnt = '0;
    logic [31:0] m_res = '0;
    int          m_phase = 0, m_wait = 0;
    logic        h_hit, h_wr, h_busy;
    logic [2:0]  h_sel;
    logic [31:0] h_rd;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_b = '0; m_m = '0; m_bs = '0; m_br = '0; m_dir = '0; m_ctrl = '0;
            m_busy = 0; m_dn = 0; m_err = 0; m_to = 0; m_done = 0; m_cnt = '0;
            m_res = '0; m_phase = 0; m_wait = 0;
        end else begin
            h_hit  = start && (ciN == ID);
            h_wr   = valueA[9];
            h_sel  = valueA[12:10];
            h_busy = m_busy;
            case (h_sel)
                3'd1: h_rd = m_b;
                3'd2: h_rd = 32'(m_m);
                3'd3: h_rd = 32'(m_bs);
                3'd4: h_rd = 32'(m_br);
                3'd5: h_rd = (32'(eng) << 8) | (32'(m_to) << 5) | (32'(m_err) << 4)
                             | (32'(m_dn) << 3) | (32'(h_busy) << 2) | 32'(m_dir);
                3'd6: h_rd = 32'(m_cnt);
                default: h_rd = 0;
            endcase
            m_done = h_hit;
            m_res  = (h_hit && !h_wr) ? h_rd : 0;
            if (h_hit && h_wr && h_sel == 3'd5 && valueB[31]) begin
                m_dn = 0; m_err = 0; m_to = 0;
            end
            if (m_phase == 1) begin
                if (eng != 0) begin
                    m_phase = 2; m_cnt = 1;
                    if (eng == 7) m_err = 1;
                end else if (m_wait + 1 == LT) begin
                    m_phase = 0; m_to = 1; m_err = 1; m_busy = 0; m_ctrl = 0;
                end else m_wait++;
            end else if (m_phase == 2) begin
                if (eng == 0) begin
                    m_phase = 3; m_ctrl = 0; m_dn = 1; m_busy = 0;
                end else begin
                    if (m_cnt != 16'hFFFF) m_cnt++;
                    if (eng == 7) m_err = 1;
                end
            end else if (m_phase == 3) m_phase = 0;
            if (h_hit && h_wr && !h_busy) begin
                if (h_sel == 3'd1) m_b  = valueB;
                if (h_sel == 3'd2) m_m  = valueB[8:0];
                if (h_sel == 3'd3) m_bs = valueB[9:0];
                if (h_sel == 3'd4) m_br = valueB[7:0];
                if (h_sel == 3'd5 && (valueB[1:0] == 2'b01 || valueB[1:0] == 2'b10)) begin
                    if (m_bs == 0) m_err = 1;
                    else begin
                        m_phase = 1; m_wait = 0; m_cnt = 0; m_busy = 1;
                        m_ctrl = valueB[1:0]; m_dir = valueB[1:0];
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        check("done", 32'(done), 32'(m_done));
        check("result", result, m_res);
        check("bAddrOut", bAddrOut, m_b);
        check("mAddrOut", 32'(mAddrOut), 32'(m_m));
        check("blockSOut", 32'(blockSOut), 32'(m_bs));
        check("burstSOut", 32'(burstSOut), 32'(m_br));
        check("controlOut", 32'(controlOut), 32'(m_ctrl));
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic ci(input logic [7:0] id, input logic [2:0] sel, input logic wr,
                      input logic [31:0] data, output logic [31:0] rdat, output logic dn);
        start = 1'b1; ciN = id; valueA = {19'd0, sel, wr, 9'd0}; valueB = data;
        cyc();
        start = 1'b0; ciN = 8'h00; valueA = '0; valueB = '0;
        @(negedge clock);
        rdat = result;
        dn = done;
        cyc();
    endtask

    task automatic wr_reg(input logic [2:0] sel, input logic [31:0] data);
        logic [31:0] r;
        logic d;
        ci(ID, sel, 1'b1, data, r, d);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] sel, input logic [31:0] exp);
        logic [31:0] r;
        logic d;
        ci(ID, sel, 1'b0, 32'h0, r, d);
        check({name, "_done"}, 32'(d), 32'd1);
        check(name, r, exp);
    endtask

    initial begin
        logic [31:0] r;
        logic d;
        int on_cnt;
        repeat (3) cyc();
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_ctrl", 32'(controlOut), 32'd0);
        check("rst_baddr", bAddrOut, 32'd0);
        #2 reset = 1'b1;
        cyc();

        // 1: bus->SRAM transfer with 20 active engine cycles
        wr_reg(3'd1, 32'h1000);
        wr_reg(3'd2, 32'd4);
        wr_reg(3'd3, 32'd8);
        wr_reg(3'd4, 32'd3);
        wr_reg(3'd5, 32'h1);
        check("t1_ctrl_arm", 32'(controlOut), 32'h1);
        for (int i = 0; i < 20; i++) begin
            eng = 4'((i % 4) + 1);
            cyc();
        end
        eng = 4'd0;
        repeat (3) cyc();
        rd_chk("t1_count", 3'd6, 32'd20);
        rd_chk("t1_status", 3'd5, 32'h09);
        rd_chk("t1_baddr", 3'd1, 32'h1000);
        rd_chk("t1_maddr", 3'd2, 32'd4);
        rd_chk("t1_blocks", 3'd3, 32'd8);
        rd_chk("t1_bursts", 3'd4, 32'd3);

        // 2: foreign opcode ignored; unmapped selects read zero
        ci(ID + 8'd1, 3'd1, 1'b1, 32'hDEAD, r, d);
        check("t2_foreign_done", 32'(d), 32'd0);
        rd_chk("t2_baddr_kept", 3'd1, 32'h1000);
        rd_chk("t2_sel0", 3'd0, 32'd0);
        rd_chk("t2_sel7", 3'd7, 32'd0);

        // 3: engine never leaves idle -> timeout
        on_cnt = 0;
        fork
            for (int i = 0; i < 40; i++) begin
                @(negedge clock);
                if (controlOut != 2'b00) on_cnt++;
            end
            wr_reg(3'd5, 32'h8000_0002);
        join
        check("t3_arm_cycles", 32'(on_cnt), 32'd16);
        check("t3_ctrl", 32'(controlOut), 32'd0);
        rd_chk("t3_status", 3'd5, 32'h32);

        // 4: engine error for 3 cycles, then sticky clear
        wr_reg(3'd5, 32'h8000_0001);
        eng = 4'd7;
        repeat (3) cyc();
        eng = 4'd0;
        repeat (3) cyc();
        rd_chk("t4_status", 3'd5, 32'h19);
        rd_chk("t4_count", 3'd6, 32'd3);
        wr_reg(3'd5, 32'h8000_0000);
        rd_chk("t4_cleared", 3'd5, 32'h01);

        // 5: writes while busy are dropped
        wr_reg(3'd5, 32'h1);
        fork
            begin
                eng = 4'd1;
                repeat (12) cyc();
                eng = 4'd0;
            end
            begin
                wr_reg(3'd3, 32'd50);
                rd_chk("t5_blocks_busy", 3'd3, 32'd8);
                wr_reg(3'd5, 32'h2);
                rd_chk("t5_status_busy", 3'd5, 32'h105);
                check("t5_ctrl_kept", 32'(controlOut), 32'h1);
            end
        join
        repeat (3) cyc();
        rd_chk("t5_status_end", 3'd5, 32'h09);
        rd_chk("t5_blocks_end", 3'd3, 32'd8);

        // 6: async reset mid-transfer, then zero-size launch
        wr_reg(3'd5, 32'h8000_0001);
        fork
            begin
                eng = 4'd2;
                repeat (30) cyc();
                eng = 4'd0;
            end
            begin
                repeat (6) cyc();
                @(negedge clock);
                check("t6_ctrl_run", 32'(controlOut), 32'h1);
                #2 reset = 1'b0;
                #1;
                check("t6_rst_ctrl", 32'(controlOut), 32'd0);
                check("t6_rst_baddr", bAddrOut, 32'd0);
                check("t6_rst_blocks", 32'(blockSOut), 32'd0);
                check("t6_rst_done", 32'(done), 32'd0);
                repeat (3) @(posedge clock);
                #3 reset = 1'b1;
            end
        join
        cyc();
        wr_reg(3'd5, 32'h1);
        check("t6_no_arm", 32'(controlOut), 32'd0);
        rd_chk("t6_status", 3'd5, 32'h10);
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
